// File: rtl/hot_page_mig_queue.sv
// Filters the hotness tracker's top-K snapshot against a count threshold and a
// recently-issued history, and queues surviving pages for the migration engine.
module hot_page_mig_queue #(
  parameter int ADDR_SIZE  = 28,
  parameter int CNT_SIZE   = 13,
  parameter int QDEPTH     = 8,
  parameter int HIST_DEPTH = 4,
  parameter int MIN_CNT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mig_en,
  input  logic [ADDR_SIZE-1:0] top_1_addr,
  input  logic [ADDR_SIZE-1:0] top_2_addr,
  input  logic [ADDR_SIZE-1:0] top_3_addr,
  input  logic [ADDR_SIZE-1:0] top_4_addr,
  input  logic [ADDR_SIZE-1:0] top_5_addr,
  input  logic [CNT_SIZE-1:0]  top_1_cnt,
  input  logic [CNT_SIZE-1:0]  top_2_cnt,
  input  logic [CNT_SIZE-1:0]  top_3_cnt,
  input  logic [CNT_SIZE-1:0]  top_4_cnt,
  input  logic [CNT_SIZE-1:0]  top_5_cnt,
  input  logic [2:0]           num_mig,
  input  logic                 hist_clr,
  output logic                 busy,
  output logic                 mig_addr_valid,
  output logic [ADDR_SIZE-1:0] mig_addr,
  output logic [CNT_SIZE-1:0]  mig_cnt,
  input  logic                 mig_addr_ready,
  output logic [15:0]          drop_cnt
);

  localparam int QAW = $clog2(QDEPTH);
  localparam logic [QAW:0] OCC_FULL = (QAW+1)'(QDEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  // Output handshake: a head entry transfers on any edge where
  // mig_addr_valid && mig_addr_ready; the head is held stable otherwise.

  state_t               state;
  logic [ADDR_SIZE-1:0] snap_addr [5];
  logic [CNT_SIZE-1:0]  snap_cnt  [5];
  logic [2:0]           snap_n;
  logic [2:0]           idx;

  logic [ADDR_SIZE-1:0] hist_addr [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_valid;

  logic [ADDR_SIZE-1:0] mem_addr [QDEPTH];
  logic [CNT_SIZE-1:0]  mem_cnt  [QDEPTH];
  logic [QAW-1:0]       wr_ptr, rd_ptr;
  logic [QAW:0]         occ;

  logic [ADDR_SIZE-1:0] cur_addr;
  logic [CNT_SIZE-1:0]  cur_cnt;
  logic [2:0]           n_in;
  logic                 hist_hit, qual, full, push, pop, resolved, last;

  always_comb begin
    cur_addr = snap_addr[idx];
    cur_cnt  = snap_cnt[idx];
    n_in     = (num_mig > 3'd5) ? 3'd5 : num_mig;
    hist_hit = 1'b0;
    for (int k = 0; k < HIST_DEPTH; k++)
      if (hist_valid[k] && hist_addr[k] == cur_addr) hist_hit = 1'b1;
    qual     = (cur_cnt >= CNT_SIZE'(MIN_CNT)) && !hist_hit;
    // Full is judged before any same-cycle pop, so a stalled entry waits a cycle.
    full     = (occ == OCC_FULL);
    push     = (state == SCAN) && qual && !full;
    resolved = (state == SCAN) && (!qual || !full);
    last     = (idx == snap_n - 3'd1);
    pop      = mig_addr_valid && mig_addr_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      idx    <= '0;
      snap_n <= '0;
      for (int i = 0; i < 5; i++) begin
        snap_addr[i] <= '0;
        snap_cnt[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: if (mig_en) begin
          snap_addr[0] <= top_1_addr;  snap_cnt[0] <= top_1_cnt;
          snap_addr[1] <= top_2_addr;  snap_cnt[1] <= top_2_cnt;
          snap_addr[2] <= top_3_addr;  snap_cnt[2] <= top_3_cnt;
          snap_addr[3] <= top_4_addr;  snap_cnt[3] <= top_4_cnt;
          snap_addr[4] <= top_5_addr;  snap_cnt[4] <= top_5_cnt;
          snap_n <= n_in;
          idx    <= '0;
          if (n_in != 3'd0) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: if (resolved) begin
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Newest address at slot 0; a same-cycle clear leaves only the new entry valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= '0;
    end else if (push) begin
      for (int k = 1; k < HIST_DEPTH; k++) hist_addr[k] <= hist_addr[k-1];
      hist_addr[0] <= cur_addr;
      hist_valid   <= hist_clr ? HIST_DEPTH'(1) : {hist_valid[HIST_DEPTH-2:0], 1'b1};
    end else if (hist_clr) begin
      hist_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cur_addr;
      mem_cnt[wr_ptr]  <= cur_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (state == SCAN && mig_en && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign mig_addr_valid = (occ != '0);
  assign mig_addr       = mig_addr_valid ? mem_addr[rd_ptr] : '0;
  assign mig_cnt        = mig_addr_valid ? mem_cnt[rd_ptr]  : '0;

endmodule

// File: tb/tb_hot_page_mig_queue.sv
// Bench for hot_page_mig_queue: directed scenarios plus random traffic, all
// compared every cycle against a queue-based reference model.
module tb_hot_page_mig_queue;

  localparam int AW = 28;
  localparam int CW = 13;
  localparam int QD = 8;
  localparam int HD = 4;
  localparam int MINC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mig_en = 1'b0;
  logic [AW-1:0] ta [5];
  logic [CW-1:0] tc [5];
  logic [2:0]    num_mig = '0;
  logic          hist_clr = 1'b0;
  logic          busy, mig_addr_valid, mig_addr_ready = 1'b0;
  logic [AW-1:0] mig_addr;
  logic [CW-1:0] mig_cnt;
  logic [15:0]   drop_cnt;

  int total = 0;
  int bad = 0;

  typedef struct packed { logic [AW-1:0] a; logic [CW-1:0] c; } ent_t;
  ent_t          mq[$];
  ent_t          pend[$];
  logic [AW-1:0] mh[$];
  int unsigned   mdrop = 0;

  hot_page_mig_queue #(.ADDR_SIZE(AW), .CNT_SIZE(CW), .QDEPTH(QD),
                       .HIST_DEPTH(HD), .MIN_CNT(MINC)) dut (
    .clk(clk), .rst(rst), .mig_en(mig_en),
    .top_1_addr(ta[0]), .top_2_addr(ta[1]), .top_3_addr(ta[2]),
    .top_4_addr(ta[3]), .top_5_addr(ta[4]),
    .top_1_cnt(tc[0]), .top_2_cnt(tc[1]), .top_3_cnt(tc[2]),
    .top_4_cnt(tc[3]), .top_5_cnt(tc[4]),
    .num_mig(num_mig), .hist_clr(hist_clr), .busy(busy),
    .mig_addr_valid(mig_addr_valid), .mig_addr(mig_addr), .mig_cnt(mig_cnt),
    .mig_addr_ready(mig_addr_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: pending snapshot entries, output queue and history list.
  task automatic model_update();
    ent_t e;
    bit   hit, pushed, pop, full;
    int   n;
    if (rst) begin
      mq.delete(); pend.delete(); mh.delete(); mdrop = 0;
      return;
    end
    full   = (mq.size() == QD);
    pop    = (mq.size() > 0) && mig_addr_ready;
    pushed = 0;
    e      = '0;
    if (pend.size() > 0) begin
      e   = pend[0];
      hit = 0;
      foreach (mh[k]) if (mh[k] == e.a) hit = 1;
      if (e.c >= MINC && !hit) begin
        if (!full) begin
          pushed = 1;
          void'(pend.pop_front());
        end
      end else begin
        void'(pend.pop_front());
      end
      if (mig_en && mdrop < 16'hFFFF) mdrop++;
    end else if (mig_en) begin
      n = (num_mig > 5) ? 5 : int'(num_mig);
      for (int i = 0; i < n; i++) pend.push_back('{ta[i], tc[i]});
    end
    if (pop) void'(mq.pop_front());
    if (pushed) mq.push_back(e);
    if (hist_clr) mh.delete();
    if (pushed) begin
      mh.push_front(e.a);
      if (mh.size() > HD) void'(mh.pop_back());
    end
  endtask

  task automatic check_all();
    check("busy", 32'(busy), 32'(pend.size() > 0));
    check("valid", 32'(mig_addr_valid), 32'(mq.size() > 0));
    check("addr", 32'(mig_addr), (mq.size() > 0) ? 32'(mq[0].a) : 32'd0);
    check("cnt", 32'(mig_cnt), (mq.size() > 0) ? 32'(mq[0].c) : 32'd0);
    check("drop", 32'(drop_cnt), 32'(mdrop));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_top(input int i, input logic [AW-1:0] a, input logic [CW-1:0] c);
    ta[i] = a;
    tc[i] = c;
  endtask

  task automatic pulse_en();
    mig_en = 1'b1;
    step();
    mig_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) set_top(i, '0, '0);
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(mig_addr_valid), 32'd0);

    // Basic ordering
    mig_addr_ready = 1'b1;
    set_top(0, 28'h100, 9); set_top(1, 28'h200, 7); set_top(2, 28'h300, 5);
    num_mig = 3;
    pulse_en();
    step();
    check("basic_head0", 32'(mig_addr), 32'h100);
    step();
    check("basic_head1", 32'(mig_addr), 32'h200);
    steps(4);

    // Count filter and clamp
    for (int i = 0; i < 5; i++) set_top(i, 28'h1000 + 28'(i), 13'(3 + i));
    tc[1] = 0;
    num_mig = 7;
    pulse_en();
    steps(8);

    // Dedup within and across snapshots, then after clear
    set_top(0, 28'hAA, 4); set_top(1, 28'hAA, 3); set_top(2, 28'hBB, 2);
    num_mig = 3;
    pulse_en(); steps(5);
    set_top(0, 28'hCC, 4); set_top(1, 28'hAA, 3);
    num_mig = 2;
    pulse_en(); steps(4);
    hist_clr = 1'b1; step(); hist_clr = 1'b0;
    set_top(0, 28'hAA, 4);
    num_mig = 1;
    pulse_en();
    check("dedup_reissue", 32'(busy), 32'd1);
    steps(4);

    // Backpressure, full stall, drop while busy and saturation
    mig_addr_ready = 1'b0;
    num_mig = 5;
    for (int i = 0; i < 5; i++) set_top(i, 28'h2000 + 28'(i), 13'(10 + i));
    pulse_en(); steps(6);
    for (int i = 0; i < 5; i++) set_top(i, 28'h3000 + 28'(i), 13'(20 + i));
    pulse_en(); steps(6);
    check("full_stall_busy", 32'(busy), 32'd1);
    pulse_en();
    check("drop_one", 32'(drop_cnt), 32'd1);
    mig_en = 1'b1;
    steps(70000);
    mig_en = 1'b0;
    check("drop_sat", 32'(drop_cnt), 32'hFFFF);
    mig_addr_ready = 1'b1;
    steps(14);

    // Reset on the second scan cycle with one entry queued
    rst = 1'b1; step(); rst = 1'b0;
    mig_addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) set_top(i, 28'h4000 + 28'(i), 13'(5));
    num_mig = 3;
    pulse_en();
    step();
    check("mid_one_queued", 32'(mig_addr_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_valid", 32'(mig_addr_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    mig_addr_ready = 1'b1;
    pulse_en();
    steps(5);

    // Random traffic over a small address pool to provoke history hits
    for (int c = 0; c < 3000; c++) begin
      mig_en         = ($urandom_range(0, 3) == 0);
      num_mig        = 3'($urandom_range(0, 7));
      hist_clr       = ($urandom_range(0, 19) == 0);
      mig_addr_ready = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 5; i++)
        set_top(i, 28'($urandom_range(0, 15)), 13'($urandom_range(0, 3)));
      step();
    end
    rst = 1'b0; mig_en = 1'b0; hist_clr = 1'b0; mig_addr_ready = 1'b1;
    steps(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hot_page_mig_queue.md
# hot_page_mig_queue

Downstream consumer of the page-hotness tracker's top-K result bus. On each `mig_en` pulse it snapshots the five top addresses/counts and scans the first `num_mig` of them, one per cycle. It drops entries below a count threshold or already issued recently, and pushes survivors into a FWFT queue. The queue presents migration candidates one at a time on a valid/ready port to the MMIO/migration logic.

## Interface
Parameters:
- `ADDR_SIZE`, 28: width of tracked page address.
- `CNT_SIZE`, 13: width of hotness count.
- `QDEPTH`, 8: output queue depth, power of two.
- `HIST_DEPTH`, 4: recently-issued address history entries.
- `MIN_CNT`, 1: minimum count for a candidate to qualify.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mig_en`  in  1: one-cycle pulse; top-K bus valid.
- `top_1_addr`..`top_5_addr`  in  ADDR_SIZE each: ranked addresses, 1 hottest.
- `top_1_cnt`..`top_5_cnt`  in  CNT_SIZE each: matching counts.
- `num_mig`  in  3: number of ranks to consider; values >5 clamp to 5.
- `hist_clr`  in  1: clear all history valid bits.
- `busy`  out  1: snapshot scan in progress.
- `mig_addr_valid`  out  1: queue head valid.
- `mig_addr`  out  ADDR_SIZE: queue head address.
- `mig_cnt`  out  CNT_SIZE: queue head count.
- `mig_addr_ready`  in  1: consumer accepts head.
- `drop_cnt`  out  16: saturating count of `mig_en` pulses ignored while busy.

## Operation
- FSM states are IDLE and SCAN.
- **IDLE:**
  - `mig_en`=1 latches all 10 addr/cnt inputs and `n = min(num_mig,5)`.
  - If n=0, stay in IDLE. Otherwise go to SCAN with index i=0.
- **SCAN:** evaluate latched entry i once per cycle.
  - **Qualifies** when cnt ≥ MIN_CNT and addr matches no valid history entry. The history compare is combinational over all HIST_DEPTH entries.
  - **Qualifying and queue not full:** push {addr,cnt} into the queue. Insert addr into history as a shift register: newest at 0, oldest evicted. Then i++.
  - **Qualifying and queue full:** stall at i. No push, no skip, i held.
  - **Not qualifying:** i++, no push.
  - **Exit:** when i == n-1 and the entry is resolved (pushed or skipped), return to IDLE.
- **Duplicates within one snapshot** are suppressed: the history update is visible to the next index.
- **`mig_en` while in SCAN** is ignored and increments `drop_cnt`, saturating at 0xFFFF.
- **Queue:** FWFT FIFO.
  - `mig_addr_valid` = not empty.
  - Pop on `mig_addr_valid & mig_addr_ready`.
  - Full is evaluated before the same-cycle pop, so a push into a full queue waits one cycle even if a pop occurs.
  - Simultaneous push and pop on a non-full, non-empty queue leaves occupancy unchanged.
  - Pointers wrap modulo QDEPTH. Occupancy counter width is log2(QDEPTH)+1.
- **`hist_clr`** invalidates history at the clock edge. If a push happens in the same cycle, the pushed address becomes the sole valid entry.
- **Reset behaviour:**
  - `rst` returns the FSM to IDLE and empties the queue.
  - History is invalidated and `drop_cnt` is zeroed.
  - Latched snapshot is discarded, including a reset mid-SCAN.

## Timing
- Reset values: `busy`=0, `mig_addr_valid`=0, `mig_addr`=0, `mig_cnt`=0, `drop_cnt`=0.
- `busy` = (state==SCAN), registered.
- `mig_en` sampled at edge E0; first evaluation occurs in cycle E0..E1.
- Entry i (no stall) is pushed at edge E(i+1). `mig_addr_valid` is first high after E1: 1-cycle latency from snapshot to head.
- Scan time is n cycles plus full-stall cycles. `busy` drops after the edge resolving entry n-1.
- A `mig_en` in the cycle `busy` is low is accepted.
- Consumer may hold `mig_addr_ready` high continuously. Throughput is one entry per cycle.
- Head data is stable while `mig_addr_valid` & !`mig_addr_ready`.

## Test plan
- **Basic ordering:** `num_mig`=3, addrs 0x100/0x200/0x300, cnts 9/7/5, ready=1 -> heads 0x100, 0x200, 0x300 on consecutive cycles starting one cycle after the snapshot edge; `busy` high exactly 3 cycles.
- **Count filter and clamp:** `top_2_cnt`=0, `num_mig`=7 -> 4 entries (ranks 1,3,4,5); rank 2 absent; `busy` 5 cycles.
- **Dedup:**
  - Snapshot with `top_1_addr`==`top_2_addr`=0xAA -> 0xAA issued once.
  - Second snapshot re-ranking 0xAA -> suppressed.
  - After `hist_clr` pulse, third snapshot -> 0xAA issued again.
- **Backpressure/full:** ready=0, QDEPTH=8, two 5-entry snapshots of distinct addresses -> queue holds 8, `busy` stuck on 4th entry of second snapshot; release ready -> all 10 emerge in order, no loss/duplication.
- **Drop while busy:** `mig_en` pulse during SCAN -> `drop_cnt`=1, none of its addresses queued; 70000 such pulses -> `drop_cnt`=0xFFFF.
- **Reset mid-scan:** `rst` on 2nd SCAN cycle with 1 entry queued -> next cycle `busy`=0, `mig_addr_valid`=0, `drop_cnt`=0; new snapshot with same addresses issues all of them (history cleared).
